// File: rtl/door_lock_ctrl.sv
// Password-checking controller for the electronic door lock: collects keypad
// digits, compares/stores the code, drives the strike and reports state to h_lcd.
module door_lock_ctrl #(
  parameter int                  PW_LEN         = 4,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW     = 16'h1234,
  parameter int                  MAX_FAIL       = 3,
  parameter logic [27:0]         UNLOCK_CYCLES  = 28'd5000,
  parameter logic [27:0]         MSG_CYCLES     = 28'd2000,
  parameter logic [27:0]         LOCKOUT_CYCLES = 28'd30000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] state,
  output logic       eval,
  output logic       success,
  output logic       unlock,
  output logic [2:0] digit_cnt
);

  localparam int                PW_W       = 4 * PW_LEN;
  localparam int                FAIL_W     = $clog2(MAX_FAIL + 1);
  localparam logic [2:0]        LEN_C      = 3'(PW_LEN);
  localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);

  // Encoding doubles as the LCD message index, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_NEW_PW  = 3'd6,
    S_SAVED   = 3'd7
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [27:0]       r_timer, w_timer_nxt, w_limit;
  logic [PW_W-1:0]   r_buf, w_buf_nxt, w_buf_shift;
  logic [PW_W-1:0]   r_stored, w_stored_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [FAIL_W-1:0] r_fail, w_fail_nxt;
  logic              r_match, w_match_nxt;
  logic              r_eval, r_success, r_unlock;
  logic              w_eval_nxt, w_success_nxt, w_unlock_nxt;
  logic              w_digit, w_clr, w_ent, w_chg, w_timed, w_expire;

  always_comb begin
    w_digit     = key_valid && (key_code <= 4'd9);
    w_clr       = key_valid && (key_code == 4'hA);
    w_ent       = key_valid && (key_code == 4'hB);
    w_chg       = key_valid && (key_code == 4'hC);
    w_buf_shift = PW_W'({r_buf, key_code});
    w_timed     = 1'b1;
    w_limit     = '0;
    case (r_state)
      S_OPEN:          w_limit = UNLOCK_CYCLES - 28'd1;
      S_FAIL, S_SAVED: w_limit = MSG_CYCLES - 28'd1;
      S_LOCKOUT:       w_limit = LOCKOUT_CYCLES - 28'd1;
      default:         w_timed = 1'b0;
    endcase
    w_expire = w_timed && (r_timer == w_limit);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_stored_nxt = r_stored;
    w_match_nxt  = r_match;
    w_fail_nxt   = r_fail;
    case (r_state)
      S_IDLE: begin
        if (w_digit) begin
          w_state_nxt = S_ENTER;
          w_buf_nxt   = PW_W'(key_code);
          w_cnt_nxt   = 3'd1;
        end
      end
      S_ENTER, S_NEW_PW: begin
        if (w_digit) begin
          if (r_cnt < LEN_C) begin
            w_buf_nxt = w_buf_shift;
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else if (w_clr) begin
          w_state_nxt = S_IDLE;
        end else if (w_ent) begin
          // The compare result is latched here because the buffer is wiped on exit.
          if (r_state == S_ENTER) begin
            if (r_cnt == LEN_C) begin
              w_match_nxt = (r_buf == r_stored);
              w_state_nxt = S_CHECK;
            end else begin
              w_state_nxt = S_FAIL;
            end
          end else if (r_cnt == LEN_C) begin
            w_stored_nxt = r_buf;
            w_state_nxt  = S_SAVED;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        if (w_state_nxt != r_state) begin
          w_buf_nxt = '0;
          w_cnt_nxt = '0;
        end
      end
      S_CHECK: w_state_nxt = r_match ? S_OPEN : S_FAIL;
      S_OPEN: begin
        if (w_expire)   w_state_nxt = S_IDLE;
        else if (w_chg) w_state_nxt = S_NEW_PW;
      end
      S_FAIL: begin
        if (w_expire) w_state_nxt = (r_fail == MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (w_expire) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = '0;
        end
      end
      S_SAVED: begin
        if (w_expire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt == S_FAIL) && (r_state != S_FAIL) && (r_fail != MAX_FAIL_C))
      w_fail_nxt = r_fail + 1'b1;
    if ((r_state == S_CHECK) && r_match)
      w_fail_nxt = '0;

    w_timer_nxt   = (w_state_nxt != r_state) ? 28'd0 : r_timer + 28'd1;
    w_eval_nxt    = (w_state_nxt == S_OPEN) || (w_state_nxt == S_FAIL) ||
                    (w_state_nxt == S_SAVED);
    w_success_nxt = (w_state_nxt == S_OPEN) || (w_state_nxt == S_SAVED);
    w_unlock_nxt  = (w_state_nxt == S_OPEN);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_stored  <= DEFAULT_PW;
      r_match   <= 1'b0;
      r_fail    <= '0;
      r_eval    <= 1'b0;
      r_success <= 1'b0;
      r_unlock  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_buf     <= w_buf_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stored  <= w_stored_nxt;
      r_match   <= w_match_nxt;
      r_fail    <= w_fail_nxt;
      r_eval    <= w_eval_nxt;
      r_success <= w_success_nxt;
      r_unlock  <= w_unlock_nxt;
    end
  end

  assign state     = r_state;
  assign eval      = r_eval;
  assign success   = r_success;
  assign unlock    = r_unlock;
  assign digit_cnt = r_cnt;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: directed scenarios plus random entry attempts
// scored against a digit-list model of the lock's password rules.
module tb_door_lock_ctrl;

  localparam int PW_LEN   = 4;
  localparam int MAX_FAIL = 3;
  localparam int UNLOCK_N = 20;
  localparam int MSG_N    = 10;
  localparam int LOCK_N   = 50;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [2:0] state, digit_cnt;
  logic       eval, success, unlock;

  int checks = 0;
  int errors = 0;
  int model_pw[PW_LEN];
  int model_fail;

  always #5 clk_in = ~clk_in;

  door_lock_ctrl #(
    .PW_LEN(PW_LEN), .DEFAULT_PW(16'h1234), .MAX_FAIL(MAX_FAIL),
    .UNLOCK_CYCLES(28'd20), .MSG_CYCLES(28'd10), .LOCKOUT_CYCLES(28'd50)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .state(state), .eval(eval), .success(success), .unlock(unlock),
    .digit_cnt(digit_cnt)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    model_pw = '{1, 2, 3, 4};
    model_fail = 0;
  endtask

  task automatic press_key(input logic [3:0] k);
    @(negedge clk_in);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk_in);
    key_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // Observes a timed state from its first cycle until it is left, injecting random keys.
  task automatic hold_state(input logic [2:0] exp_st, input int exp_len,
                            input logic exp_eval, input logic exp_succ,
                            input logic exp_unl, input bit allow_c, input string name);
    int cnt = 1;
    bit bad_flags = 1'b0;
    logic [3:0] k;
    checks++;
    if (state !== exp_st) begin
      errors++;
      $display("FAIL %s enter: state=%0d expected %0d", name, state, exp_st);
    end
    for (int i = 0; i < 500; i++) begin
      if ({eval, success, unlock} !== {exp_eval, exp_succ, exp_unl}) bad_flags = 1'b1;
      k = 4'($urandom_range(0, 15));
      if (!allow_c && k == 4'hC) k = 4'hD;
      key_valid = 1'($urandom_range(0, 1));
      key_code  = k;
      @(negedge clk_in);
      if (state !== exp_st) break;
      cnt++;
    end
    key_valid = 1'b0;
    checks++;
    if (cnt !== exp_len) begin
      errors++;
      $display("FAIL %s duration: held %0d cycles expected %0d", name, cnt, exp_len);
    end
    checks++;
    if (bad_flags !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: eval/success/unlock deviated from %b%b%b", name,
               exp_eval, exp_succ, exp_unl);
    end
  endtask

  task automatic fail_done(input string name);
    if (model_fail < MAX_FAIL) model_fail++;
    if (model_fail == MAX_FAIL) begin
      hold_state(3'd5, LOCK_N, 1'b0, 1'b0, 1'b0, 1'b1, {name, "_lockout"});
      model_fail = 0;
    end
    checks++;
    if (state !== 3'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL %s after_fail: state=%0d cnt=%0d expected 0/0", name, state, digit_cnt);
    end
  endtask

  task automatic attempt(input int d[8], input int n, input string name);
    bit match;
    int exp_cnt;
    match = (n >= PW_LEN);
    for (int i = 0; i < PW_LEN; i++) if (i < n && d[i] != model_pw[i]) match = 1'b0;
    for (int i = 0; i < n; i++) begin
      press_key(4'(d[i]));
      exp_cnt = (i + 1 < PW_LEN) ? i + 1 : PW_LEN;
      checks++;
      if (state !== 3'd1 || digit_cnt !== 3'(exp_cnt)) begin
        errors++;
        $display("FAIL %s digit%0d: state=%0d cnt=%0d expected 1/%0d", name, i,
                 state, digit_cnt, exp_cnt);
      end
    end
    press_key(4'hB);
    if (n >= PW_LEN) begin
      checks++;
      if (state !== 3'd2) begin
        errors++;
        $display("FAIL %s check_state: state=%0d expected 2", name, state);
      end
      @(negedge clk_in);
    end
    if (match) begin
      hold_state(3'd3, UNLOCK_N, 1'b1, 1'b1, 1'b1, 1'b0, {name, "_open"});
      model_fail = 0;
      checks++;
      if (state !== 3'd0 || digit_cnt !== 3'd0) begin
        errors++;
        $display("FAIL %s after_open: state=%0d cnt=%0d expected 0/0", name, state, digit_cnt);
      end
    end else begin
      hold_state(3'd4, MSG_N, 1'b1, 1'b0, 1'b0, 1'b1, {name, "_fail"});
      fail_done(name);
    end
  endtask

  task automatic open_door(input string name);
    for (int i = 0; i < PW_LEN; i++) press_key(4'(model_pw[i]));
    press_key(4'hB);
    @(negedge clk_in);
    checks++;
    if (state !== 3'd3 || unlock !== 1'b1) begin
      errors++;
      $display("FAIL %s open: state=%0d unlock=%b expected 3/1", name, state, unlock);
    end
    model_fail = 0;
  endtask

  // mode 0: '#' to save, 1: '#' (short or not), 2: '*' abort
  task automatic change_pw(input int d[8], input int n, input int mode, input string name);
    open_door(name);
    press_key(4'hC);
    checks++;
    if (state !== 3'd6 || unlock !== 1'b0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL %s new_pw: state=%0d unlock=%b cnt=%0d expected 6/0/0", name,
               state, unlock, digit_cnt);
    end
    for (int i = 0; i < n; i++) begin
      press_key(4'(d[i]));
      checks++;
      if (state !== 3'd6 || digit_cnt !== 3'((i + 1 < PW_LEN) ? i + 1 : PW_LEN)) begin
        errors++;
        $display("FAIL %s new_digit%0d: state=%0d cnt=%0d", name, i, state, digit_cnt);
      end
    end
    press_key(mode == 2 ? 4'hA : 4'hB);
    if (mode != 2 && n >= PW_LEN) begin
      hold_state(3'd7, MSG_N, 1'b1, 1'b1, 1'b0, 1'b1, {name, "_saved"});
      for (int i = 0; i < PW_LEN; i++) model_pw[i] = d[i];
    end
    checks++;
    if (state !== 3'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL %s after_change: state=%0d cnt=%0d expected 0/0", name, state, digit_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    checks++;
    if ({state, eval, success, unlock, digit_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d eval=%b success=%b unlock=%b cnt=%0d expected all 0",
               state, eval, success, unlock, digit_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int d[8];
    d = '{1, 2, 3, 4, 0, 0, 0, 0}; attempt(d, 4, "open_1234");
    d = '{1, 2, 3, 5, 0, 0, 0, 0}; attempt(d, 4, "wrong_1235");
    d = '{9, 9, 9, 9, 0, 0, 0, 0}; attempt(d, 4, "wrong_9999");
    d = '{4, 3, 2, 1, 0, 0, 0, 0}; attempt(d, 4, "wrong_lockout");
    d = '{1, 2, 3, 4, 0, 0, 0, 0}; attempt(d, 4, "open_after_lockout");
    d = '{1, 2, 0, 0, 0, 0, 0, 0}; attempt(d, 2, "short_entry");
    d = '{1, 2, 3, 4, 5, 6, 0, 0}; attempt(d, 6, "extra_digits");
  endtask

  task automatic test_clear(input int n, input string name);
    for (int i = 0; i < n; i++) press_key(4'($urandom_range(0, 9)));
    press_key(4'hA);
    checks++;
    if (state !== 3'd0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL %s: state=%0d cnt=%0d expected 0/0", name, state, digit_cnt);
    end
  endtask

  task automatic test_ignored_keys();
    logic [3:0] ign[5];
    ign = '{4'hB, 4'hA, 4'hC, 4'hE, 4'hF};
    for (int i = 0; i < 5; i++) begin
      press_key(ign[i]);
      checks++;
      if (state !== 3'd0 || digit_cnt !== 3'd0) begin
        errors++;
        $display("FAIL idle_ignore_%0h: state=%0d cnt=%0d expected 0/0", ign[i], state, digit_cnt);
      end
    end
    press_key(4'h7);
    press_key(4'hC);
    press_key(4'hD);
    checks++;
    if (state !== 3'd1 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL enter_ignore_cd: state=%0d cnt=%0d expected 1/1", state, digit_cnt);
    end
    @(negedge clk_in);
    key_valid = 1'b1;
    key_code  = 4'h3;
    repeat (2) @(negedge clk_in);
    key_valid = 1'b0;
    checks++;
    if (digit_cnt !== 3'd3) begin
      errors++;
      $display("FAIL held_key: cnt=%0d expected 3", digit_cnt);
    end
    press_key(4'hA);
  endtask

  task automatic test_change();
    int d[8];
    d = '{9, 8, 7, 6, 0, 0, 0, 0}; change_pw(d, 4, 0, "change_9876");
    d = '{1, 2, 3, 4, 0, 0, 0, 0}; attempt(d, 4, "old_pw_rejected");
    d = '{9, 8, 7, 6, 0, 0, 0, 0}; attempt(d, 4, "new_pw_opens");
    pulse_reset();
    d = '{1, 2, 3, 4, 0, 0, 0, 0}; attempt(d, 4, "default_after_reset");
  endtask

  task automatic test_expiry_drop();
    open_door("expiry_drop");
    repeat (UNLOCK_N - 1) @(negedge clk_in);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL expiry_last_cycle: state=%0d expected 3", state);
    end
    key_valid = 1'b1;
    key_code  = 4'hC;
    @(negedge clk_in);
    key_valid = 1'b0;
    checks++;
    if (state !== 3'd0 || unlock !== 1'b0) begin
      errors++;
      $display("FAIL expiry_key_dropped: state=%0d unlock=%b expected 0/0", state, unlock);
    end
  endtask

  task automatic test_async_reset();
    open_door("async_reset");
    repeat (5) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || unlock !== 1'b0 || eval !== 1'b0 || success !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d unlock=%b eval=%b success=%b expected 0",
               state, unlock, eval, success);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int d[8];
    int n, sel;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) d[i] = $urandom_range(0, 9);
      case (sel)
        0: begin
          for (int i = 0; i < PW_LEN; i++) d[i] = model_pw[i];
          attempt(d, PW_LEN + $urandom_range(0, 2), "rand_correct");
        end
        1: attempt(d, PW_LEN, "rand_guess");
        2: attempt(d, $urandom_range(1, PW_LEN - 1), "rand_short");
        3: test_clear($urandom_range(1, 5), "rand_clear");
        default: begin
          n = $urandom_range(0, 2);
          change_pw(d, (n == 1) ? $urandom_range(1, PW_LEN - 1) : PW_LEN, n, "rand_change");
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear(2, "clear_12");
    test_ignored_keys();
    test_change();
    test_expiry_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
